ea_pipe_unit: RTL and testbench
===============================

// Module: ea_pipe_unit
// PURPOSE
//  Parametrised, pipelined LC-3 effective-address generator; successor to the combinational EA adder.
//  Selects base (PC or RS1), sign-extends the IR offset field (6/9/11 bits or zero) to WIDTH, adds,
//  and returns EA over a valid/ready stream with a tag. Sits between decode and the MAR/LD-ST path.
// PARAMETERS
//  WIDTH          16       address/data width; offsets sign-extend to WIDTH
//  TAG_W          4        width of opaque tag carried alongside each request (e.g. DR id)
//  PRIV_LO_END    'h2FFF   last address of low privileged region (ACV check only)
//  PRIV_HI_START  'hFE00   first address of high privileged region/device space (ACV check only)
// PORTS
//  CLK        in   1       single clock, rising edge
//  RESET      in   1       synchronous, active-high
//  IN_VALID   in   1       request present
//  IN_READY   out  1       unit accepts request this cycle
//  PC         in   WIDTH   incremented PC of the instruction
//  RS1_DATA   in   WIDTH   base register value
//  CONTROL    in   3       [2]=base sel (0 PC,1 RS1); [1:0]=offset sel (00 zero,01 IR[5:0],10 IR[8:0],11 IR[10:0])
//  IR         in   16      instruction word
//  IN_TAG     in   TAG_W   tag, returned unchanged with result
//  PRIV       in   1       1 = supervisor mode (ACV check only)
//  OUT_VALID  out  1       EA result present
//  OUT_READY  in   1       consumer accepts result
//  EA         out  WIDTH   effective address
//  OUT_TAG    out  TAG_W   tag of the result
//  ACV_FAULT  out  1       access-control violation for this result
// BEHAVIOUR
//  - Two stages. S1: register base mux output, sign-extended offset, tag, PRIV. S2: register sum.
//  - Latency 2 cycles accept->OUT_VALID; throughput 1 result/cycle when OUT_READY held high.
//  - Stage k advances when stage k empty or next stage advancing; s2_free = !s2_v | OUT_READY;
//    IN_READY = !s1_v | s2_free (combinational from OUT_READY, no skid buffer).
//  - Transfer on IN_VALID&IN_READY / OUT_VALID&OUT_READY. While OUT_VALID&!OUT_READY, EA/OUT_TAG/ACV_FAULT hold.
//  - Simultaneous pop at S2 and push at S1 in same cycle: both happen, no bubble, no loss.
//  - Arithmetic: EA = base + sext(offset) mod 2^WIDTH; carry discarded, wrap xFFFF+1 -> x0000.
//  - Offset 00 selects zero (EA = base, JMP/JSRR). IR bits above WIDTH ignored if WIDTH<16 n/a; WIDTH>=16.
//  - Reset: s1_v=s2_v=0, OUT_VALID=0, EA=0, OUT_TAG=0, ACV_FAULT=0; IN_READY=1 the cycle after reset.
//    Reset mid-operation drops all in-flight requests; no result emitted for them.
//  - Inputs other than IN_VALID are don't-care when IN_VALID=0; regs not updated on non-transfer.
// CONFIGURATION
//  - Macro LC3_EA_ACV_EN defined: S2 computes ACV_FAULT = !PRIV_s1 & (sum<=PRIV_LO_END | sum>=PRIV_HI_START),
//    registered with EA; result still delivered (consumer decides trap).
//  - Not defined: ACV_FAULT tied 0, PRIV unused, PRIV_* parameters unused; no comparator logic.
// STRUCTURE
//  - Package lc3_ea_pkg: CONTROL field localparams (EA_BASE_PC/RS1, EA_OFS_ZERO/6/9/11),
//    sext function parametrised on WIDTH, default privileged-region bounds.
//  - One sub-module ea_pipe_stage: valid/ready register slice (data width param), instantiated twice;
//    S1 input muxing and S2 adder/comparator live in the top.
// TESTING
//  - Reset: RESET=1 2 cycles mid-stream -> OUT_VALID=0, EA=0, in-flight tags never appear.
//  - LDR: CONTROL=101, RS1_DATA=x3000, IR[5:0]=6'b111110 -> EA=x2FFE two cycles after accept.
//  - BR/LD: CONTROL=010, PC=x3001, IR[8:0]=x0FF -> EA=x3100; IR[8:0]=x100 -> EA=x2F01.
//  - JSR wrap: CONTROL=011, PC=xFFFF, IR[10:0]=x001 -> EA=x0000; JMP CONTROL=100 RS1=x1234 -> x1234.
//  - Back-pressure: stream tags 1..6 with OUT_READY low cycles 3-5 -> IN_READY drops once both stages full,
//    all 6 results in order, held stable while stalled, none lost/duplicated.
//  - LC3_EA_ACV_EN: PRIV=0, EA=x2FFF -> ACV_FAULT=1; EA=x3000 -> 0; EA=xFE00 -> 1; PRIV=1 -> 0 for all.

Source files
------------

// File: rtl/lc3_ea_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_ea_pkg (package)
//  Description : Shared definitions for the LC-3 pipelined effective-address
//                unit:
//                  - CONTROL field encodings
//                  - default privileged-region bounds
//                  - offset sign-extension helper
//  Revision    : 1.0  initial release
// ============================================================================
package lc3_ea_pkg;

   // CONTROL[2]: base select
   localparam logic EA_BASE_PC  = 1'b0;
   localparam logic EA_BASE_RS1 = 1'b1;

   // CONTROL[1:0]: offset select
   localparam logic [1:0] EA_OFS_ZERO = 2'b00;
   localparam logic [1:0] EA_OFS_6    = 2'b01;
   localparam logic [1:0] EA_OFS_9    = 2'b10;
   localparam logic [1:0] EA_OFS_11   = 2'b11;

   // Default privileged-region bounds (16-bit LC-3 memory map)
   localparam logic [15:0] DEF_PRIV_LO_END   = 16'h2FFF;
   localparam logic [15:0] DEF_PRIV_HI_START = 16'hFE00;

   // Sign-extends the selected IR offset field to 16 bits. The result is
   // signed, so the caller widens it to any WIDTH >= 16 with a size cast
   // that keeps the sign.
   function automatic logic signed [15:0] ea_sext16(input logic [15:0] ir,
                                                    input logic [1:0]  sel);
      logic signed [15:0] ofs;
      case (sel)
         EA_OFS_6:  ofs = {{10{ir[5]}},  ir[5:0]};
         EA_OFS_9:  ofs = {{7{ir[8]}},   ir[8:0]};
         EA_OFS_11: ofs = {{5{ir[10]}},  ir[10:0]};
         default:   ofs = '0;
      endcase
      return ofs;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ea_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ea_pipe_stage
//  Description : One valid/ready register slice, with no skid buffer.
//                The slice loads whenever it is empty or its content is
//                leaving this cycle, so o_ready depends combinationally on
//                i_ready.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                i_valid/o_ready upstream handshake, i_data payload in
//                o_valid/i_ready downstream handshake, o_data payload out
//  Revision    : 1.0  initial release
// ============================================================================
module ea_pipe_stage #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [DW-1:0] o_data
);

   logic          r_valid;
   logic [DW-1:0] r_data;

   assign o_ready = !r_valid | i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   // Data only loads on an actual transfer in, so a stalled or drained
   // slice keeps presenting its last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (o_ready) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ea_pipe_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ea_pipe_unit
//  Description : Two-stage pipelined LC-3 effective-address generator.
//                Pipeline stages:
//                  - S1 registers the base (PC or RS1), the sign-extended
//                    offset, the tag and PRIV.
//                  - S2 registers EA = base + offset (mod 2^WIDTH) and the
//                    access-control flag.
//  Config      : LC3_EA_ACV_EN - when defined, ACV_FAULT flags unprivileged
//                accesses to the low/high privileged regions. Otherwise
//                ACV_FAULT is 0 and PRIV is ignored.
//  Ports       : CLK, RESET                     clock, sync active-high reset
//                IN_VALID/IN_READY              request handshake
//                PC, RS1_DATA, CONTROL, IR      operands and selects
//                IN_TAG, PRIV                   tag and supervisor flag
//                OUT_VALID/OUT_READY            result handshake
//                EA, OUT_TAG, ACV_FAULT         result
//  Revision    : 1.0  initial release
// ============================================================================
module ea_pipe_unit
   import lc3_ea_pkg::*;
#(
   parameter int               WIDTH         = 16,
   parameter int               TAG_W         = 4,
   parameter logic [WIDTH-1:0] PRIV_LO_END   = WIDTH'(DEF_PRIV_LO_END),
   parameter logic [WIDTH-1:0] PRIV_HI_START = WIDTH'(DEF_PRIV_HI_START)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] PC,
   input  logic [WIDTH-1:0] RS1_DATA,
   input  logic [2:0]       CONTROL,
   input  logic [15:0]      IR,
   input  logic [TAG_W-1:0] IN_TAG,
   input  logic             PRIV,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] EA,
   output logic [TAG_W-1:0] OUT_TAG,
   output logic             ACV_FAULT
);

   // ---------------- S1 operand selection ----------------
   logic [WIDTH-1:0]   w_base;
   logic [WIDTH-1:0]   w_ofs;
   logic signed [15:0] w_ofs16;

   assign w_base  = (CONTROL[2] == EA_BASE_RS1) ? RS1_DATA : PC;
   assign w_ofs16 = ea_sext16(IR, CONTROL[1:0]);
   assign w_ofs   = WIDTH'(w_ofs16);   // signed cast: sign-extends to WIDTH

`ifdef LC3_EA_ACV_EN
   localparam int c_S1_W = 2*WIDTH + TAG_W + 1;
   localparam int c_S2_W = WIDTH + TAG_W + 1;
`else
   localparam int c_S1_W = 2*WIDTH + TAG_W;
   localparam int c_S2_W = WIDTH + TAG_W;
`endif

   logic              w_s1_valid;
   logic              w_s1_ready;
   logic [c_S1_W-1:0] w_s1_in;
   logic [c_S1_W-1:0] w_s1_out;
   logic [WIDTH-1:0]  w_s1_base;
   logic [WIDTH-1:0]  w_s1_ofs;
   logic [TAG_W-1:0]  w_s1_tag;
   logic [WIDTH-1:0]  w_sum;
   logic [c_S2_W-1:0] w_s2_in;
   logic [c_S2_W-1:0] w_s2_out;
   logic              w_unused_bits;

   assign w_sum = w_s1_base + w_s1_ofs;   // carry out discarded: wraps

`ifdef LC3_EA_ACV_EN
   logic w_s1_priv;
   logic w_acv;

   assign w_s1_in = {w_base, w_ofs, IN_TAG, PRIV};
   assign {w_s1_base, w_s1_ofs, w_s1_tag, w_s1_priv} = w_s1_out;

   // Result is still delivered on a fault; the consumer decides to trap.
   assign w_acv   = !w_s1_priv & ((w_sum <= PRIV_LO_END) | (w_sum >= PRIV_HI_START));
   assign w_s2_in = {w_sum, w_s1_tag, w_acv};
   assign {EA, OUT_TAG, ACV_FAULT} = w_s2_out;

   assign w_unused_bits = ^IR[15:11];
`else
   assign w_s1_in = {w_base, w_ofs, IN_TAG};
   assign {w_s1_base, w_s1_ofs, w_s1_tag} = w_s1_out;

   assign w_s2_in   = {w_sum, w_s1_tag};
   assign {EA, OUT_TAG} = w_s2_out;
   assign ACV_FAULT = 1'b0;

   assign w_unused_bits = ^{IR[15:11], PRIV, PRIV_LO_END, PRIV_HI_START};
`endif

   // ---------------- pipeline slices ----------------
   ea_pipe_stage #(.DW(c_S1_W)) u_s1 (
      .clk     (CLK),
      .rst     (RESET),
      .i_valid (IN_VALID),
      .o_ready (IN_READY),
      .i_data  (w_s1_in),
      .o_valid (w_s1_valid),
      .i_ready (w_s1_ready),
      .o_data  (w_s1_out)
   );

   ea_pipe_stage #(.DW(c_S2_W)) u_s2 (
      .clk     (CLK),
      .rst     (RESET),
      .i_valid (w_s1_valid),
      .o_ready (w_s1_ready),
      .i_data  (w_s2_in),
      .o_valid (OUT_VALID),
      .i_ready (OUT_READY),
      .o_data  (w_s2_out)
   );

endmodule
`default_nettype wire

// File: tb/tb_ea_pipe_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ea_pipe_unit
//  Description : Scoreboard bench for ea_pipe_unit. The driver pushes the
//                hand-computed expected result on every accepted request.
//                A negedge monitor compares against the queue head whenever
//                OUT_VALID is high, and pops on OUT_READY.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ea_pipe_unit;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        IN_VALID;
   logic        IN_READY;
   logic [15:0] PC;
   logic [15:0] RS1_DATA;
   logic [2:0]  CONTROL;
   logic [15:0] IR;
   logic [3:0]  IN_TAG;
   logic        PRIV;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [15:0] EA;
   logic [3:0]  OUT_TAG;
   logic        ACV_FAULT;

   ea_pipe_unit #(.WIDTH(16), .TAG_W(4)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .PC        (PC),
      .RS1_DATA  (RS1_DATA),
      .CONTROL   (CONTROL),
      .IR        (IR),
      .IN_TAG    (IN_TAG),
      .PRIV      (PRIV),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .EA        (EA),
      .OUT_TAG   (OUT_TAG),
      .ACV_FAULT (ACV_FAULT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0] ea;
      logic [3:0]  tag;
      logic        acv;
      int          cyc;
      bit          chk_lat;
   } exp_t;

   exp_t q[$];
   int   total    = 0;
   int   bad      = 0;
   int   cyc      = 0;
   int   n_pop    = 0;
   bit   saw_stall = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic exp_acv(input logic [15:0] ea, input logic priv);
`ifdef LC3_EA_ACV_EN
      return !priv && ((ea <= 16'h2FFF) || (ea >= 16'hFE00));
`else
      return 1'b0 & priv & ea[0];
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, got, want);
      end
   endtask

   task automatic check_idle(input string name);
      chk({name, ".out_valid"}, 32'(OUT_VALID), 32'd0);
      chk({name, ".ea"},        32'(EA),        32'd0);
      chk({name, ".out_tag"},   32'(OUT_TAG),   32'd0);
      chk({name, ".acv"},       32'(ACV_FAULT), 32'd0);
      chk({name, ".in_ready"},  32'(IN_READY),  32'd1);
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [2:0] ctrl, input logic [15:0] pc,
                       input logic [15:0] rs1, input logic [15:0] ir,
                       input logic [3:0] tag, input logic priv,
                       input logic [15:0] exp_ea, input bit lat);
      int   waited = 0;
      bit   done   = 1'b0;
      exp_t e;
      IN_VALID = 1'b1;
      CONTROL  = ctrl;
      PC       = pc;
      RS1_DATA = rs1;
      IR       = ir;
      IN_TAG   = tag;
      PRIV     = priv;
      while (!done) begin
         @(negedge CLK);
         if (IN_READY) begin
            e.ea      = exp_ea;
            e.tag     = tag;
            e.acv     = exp_acv(exp_ea, priv);
            e.cyc     = cyc + 2;
            e.chk_lat = lat;
            q.push_back(e);
            done = 1'b1;
         end else if (++waited > 100) begin
            total++;
            bad++;
            $display("FAIL accept_timeout tag=%0h got=no_accept want=accept", tag);
            done = 1'b1;
         end
         @(posedge CLK);
         #1;
      end
      IN_VALID = 1'b0;
      IR       = 16'hDEAD;
   endtask

   task automatic wait_drain(input string name);
      int w = 0;
      while (q.size() != 0 && w < 60) begin
         @(posedge CLK);
         w++;
      end
      #1;
      chk({name, ".drain_left"}, 32'(q.size()), 32'd0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge CLK) begin
      exp_t e;
      if (RESET !== 1'b1) begin
         if (IN_VALID && !IN_READY) saw_stall = 1'b1;
         if (OUT_VALID) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_result: got ea=%h tag=%0h want=none", EA, OUT_TAG);
            end else begin
               e = q[0];
               if (EA !== e.ea || OUT_TAG !== e.tag || ACV_FAULT !== e.acv) begin
                  bad++;
                  $display("FAIL result: got ea=%h tag=%0h acv=%b want ea=%h tag=%0h acv=%b",
                           EA, OUT_TAG, ACV_FAULT, e.ea, e.tag, e.acv);
               end
               if (OUT_READY) begin
                  if (e.chk_lat) begin
                     total++;
                     if (cyc != e.cyc) begin
                        bad++;
                        $display("FAIL latency tag=%0h: got cycle=%0d want cycle=%0d", e.tag, cyc, e.cyc);
                     end
                  end
                  void'(q.pop_front());
                  n_pop++;
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int pop0;
      RESET     = 1'b1;
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      PC        = '0;
      RS1_DATA  = '0;
      CONTROL   = '0;
      IR        = '0;
      IN_TAG    = '0;
      PRIV      = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      @(negedge CLK);
      check_idle("reset");
      @(posedge CLK);
      #1;

      // Directed vectors, back-to-back with OUT_READY high
      send(3'b101, 16'h0000, 16'h3000, 16'h003E, 4'h1, 1'b1, 16'h2FFE, 1);  // LDR -2
      send(3'b010, 16'h3001, 16'h0000, 16'h00FF, 4'h2, 1'b1, 16'h3100, 1);  // LD +255
      send(3'b010, 16'h3001, 16'h0000, 16'h0100, 4'h3, 1'b1, 16'h2F01, 1);  // LD -256
      send(3'b011, 16'hFFFF, 16'h0000, 16'h0001, 4'h4, 1'b1, 16'h0000, 1);  // JSR wrap
      send(3'b100, 16'h5555, 16'h1234, 16'hFFFF, 4'h5, 1'b1, 16'h1234, 1);  // JMP
      send(3'b001, 16'h3000, 16'h0000, 16'h003F, 4'h6, 1'b0, 16'h2FFF, 1);  // lo end
      send(3'b001, 16'h2FFF, 16'h0000, 16'h0001, 4'h7, 1'b0, 16'h3000, 1);  // user
      send(3'b111, 16'h0000, 16'hFE01, 16'h07FF, 4'h8, 1'b0, 16'hFE00, 1);  // hi start
      send(3'b001, 16'h3000, 16'h0000, 16'h003F, 4'h9, 1'b1, 16'h2FFF, 1);  // supervisor
      send(3'b110, 16'h0000, 16'h0000, 16'h01FF, 4'hA, 1'b1, 16'hFFFF, 1);  // 9-bit -1
      send(3'b101, 16'h0000, 16'h1000, 16'hFFE0, 4'hB, 1'b0, 16'h0FE0, 1);  // 6-bit -32
      wait_drain("directed");

      // Back-pressure: tags 1..6, OUT_READY low for three cycles
      pop0      = n_pop;
      saw_stall = 1'b0;
      fork
         begin
            for (int t = 1; t <= 6; t++) begin
               logic [15:0] v;
               v = 16'(t) << 8;
               send(3'b100, 16'h0000, v, 16'h0000, 4'(t), 1'b1, v, 0);
            end
         end
         begin
            repeat (2) @(posedge CLK);
            #1 OUT_READY = 1'b0;
            repeat (3) @(posedge CLK);
            #1 OUT_READY = 1'b1;
         end
      join
      wait_drain("backpressure");
      chk("bp.in_ready_dropped", 32'(saw_stall), 32'd1);
      chk("bp.result_count", 32'(n_pop - pop0), 32'd6);

      // Reset mid-stream: tags E and F are in flight and must vanish
      send(3'b100, 16'h0000, 16'hAAAA, 16'h0000, 4'hE, 1'b1, 16'hAAAA, 0);
      send(3'b100, 16'h0000, 16'hBBBB, 16'h0000, 4'hF, 1'b1, 16'hBBBB, 0);
      RESET = 1'b1;
      q.delete();
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      @(negedge CLK);
      check_idle("midreset");
      repeat (3) @(negedge CLK);
      chk("midreset.no_ghost", 32'(OUT_VALID), 32'd0);
      @(posedge CLK);
      #1;
      send(3'b100, 16'h0000, 16'hBEEF, 16'h0000, 4'hC, 1'b1, 16'hBEEF, 1);
      wait_drain("post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
